// File: rtl/cfg_req_64to32_bridge_pkg.sv
// cfg_req_64to32_bridge_pkg: shared config request/ack types, bridge states and helpers
package cfg_req_64to32_bridge_pkg;

    typedef enum logic [3:0] {
        MRD   = 4'h0,
        MWR   = 4'h1,
        IORD  = 4'h2,
        IOWR  = 4'h3,
        CFGRD = 4'h4,
        CFGWR = 4'h5,
        CRRD  = 4'h6,
        CRWR  = 4'h7
    } cfg_opcode_t;

    typedef struct packed {
        logic        valid;
        cfg_opcode_t opcode;
        logic [47:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        logic [7:0]  sai;
        logic [7:0]  fid;
        logic [2:0]  bar;
    } cfg_req_64bit_t;

    typedef struct packed {
        logic        valid;
        cfg_opcode_t opcode;
        logic [47:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [7:0]  sai;
        logic [7:0]  fid;
        logic [2:0]  bar;
    } cfg_req_32bit_t;

    typedef struct packed {
        logic        read_valid;
        logic        read_miss;
        logic        write_valid;
        logic        write_miss;
        logic        sai_successfull;
        logic [63:0] data;
    } cfg_ack_64bit_t;

    typedef struct packed {
        logic        read_valid;
        logic        read_miss;
        logic        write_valid;
        logic        write_miss;
        logic        sai_successfull;
        logic [31:0] data;
    } cfg_ack_32bit_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        WAIT_LO,
        ISSUE_HI,
        WAIT_HI,
        RESP
    } bridge_state_t;

    typedef struct packed {
        logic        rm;
        logic        wm;
        logic        sai;
        logic [31:0] data;
    } half_res_t;

    // A half that is never issued must not disturb the merged ack.
    localparam half_res_t HALF_NONE = '{rm: 1'b0, wm: 1'b0, sai: 1'b1, data: 32'h0};

    localparam int CR_HI_DWORD_BIT = 2;

    function automatic logic f_cfg_is_write(input cfg_opcode_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/cfg_req_64to32_bridge_ack_timer.sv
// cfg_ack_timer: saturating wait counter with clear, enable and terminal count
module cfg_ack_timer #(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [CNT_W-1:0] r_cnt;

    assign o_tc = r_cnt == CNT_W'(TIMEOUT_CYC - 1);

    // Count wait cycles, holding at terminal count until cleared
    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_en && !o_tc)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/cfg_req_64to32_bridge.sv
// cfg_req_64to32_bridge: splits 64-bit config accesses into 32-bit CR accesses and merges the acks
module cfg_req_64to32_bridge
    import cfg_req_64to32_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  cfg_req_64bit_t up_req,
    output logic           up_ready,
    output cfg_ack_64bit_t up_ack,
    output cfg_req_32bit_t dn_req,
    input  cfg_ack_32bit_t dn_ack,
    output logic           timeout_pulse,
    output logic           spurious_ack
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    bridge_state_t  r_state, w_nxt;
    cfg_req_64bit_t r_req, w_src;
    half_res_t      r_lo, r_hi, w_lo, w_hi, w_res;
    cfg_ack_64bit_t r_up_ack, w_up_ack;
    cfg_req_32bit_t r_dn_req, w_dn;
    logic           r_ready, r_to, r_sp;
    logic           w_tc, w_ack, w_in_wait, w_wr, w_miss, w_hi_sel;
    logic [47:0]    w_dn_addr;

    assign w_ack     = dn_ack.read_valid | dn_ack.write_valid | dn_ack.read_miss | dn_ack.write_miss;
    assign w_in_wait = r_state == WAIT_LO || r_state == WAIT_HI;
    assign w_wr      = f_cfg_is_write(r_req.opcode);
    assign w_src     = r_state == IDLE ? up_req : r_req;
    assign w_hi_sel  = w_nxt == ISSUE_HI;

    cfg_ack_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == ISSUE_LO || r_state == ISSUE_HI),
        .i_en  (w_in_wait),
        .o_tc  (w_tc)
    );

    // Next state and per-half results; an ack beats a coincident terminal count
    always_comb begin
        w_nxt = r_state;
        w_lo  = r_lo;
        w_hi  = r_hi;
        w_res = w_ack ? half_res_t'{rm: dn_ack.read_miss, wm: dn_ack.write_miss,
                                    sai: dn_ack.sai_successfull, data: dn_ack.data}
                      : half_res_t'{rm: !w_wr, wm: w_wr, sai: 1'b0, data: 32'h0};
        case (r_state)
            IDLE: if (up_req.valid) begin
                w_nxt = (up_req.be[3:0] != 4'h0 || up_req.be[7:4] == 4'h0) ? ISSUE_LO : ISSUE_HI;
                w_lo  = HALF_NONE;
                w_hi  = HALF_NONE;
            end
            ISSUE_LO: w_nxt = WAIT_LO;
            ISSUE_HI: w_nxt = WAIT_HI;
            WAIT_LO: if (w_ack || w_tc) begin
                w_nxt = r_req.be[7:4] != 4'h0 ? ISSUE_HI : RESP;
                w_lo  = w_res;
            end
            WAIT_HI: if (w_ack || w_tc) begin
                w_nxt = RESP;
                w_hi  = w_res;
            end
            default: w_nxt = IDLE;
        endcase
        w_miss   = w_lo.rm | w_lo.wm | w_hi.rm | w_hi.wm;
        w_up_ack = '{read_valid:      !w_wr && !w_miss,
                     read_miss:       w_lo.rm | w_hi.rm,
                     write_valid:     w_wr && !w_miss,
                     write_miss:      w_lo.wm | w_hi.wm,
                     sai_successfull: w_lo.sai & w_hi.sai,
                     data:            {w_hi.data, w_lo.data}};
    end

    // Build the downstream access for whichever half is about to issue
    always_comb begin
        w_dn_addr = {w_src.addr[47:3], 3'b000};
        w_dn_addr[CR_HI_DWORD_BIT] = w_hi_sel;
        w_dn = '{valid:  w_src.valid,
                 opcode: w_src.opcode,
                 addr:   w_dn_addr,
                 be:     w_hi_sel ? w_src.be[7:4] : w_src.be[3:0],
                 data:   w_hi_sel ? w_src.data[63:32] : w_src.data[31:0],
                 sai:    w_src.sai,
                 fid:    w_src.fid,
                 bar:    w_src.bar};
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_req    <= '0;
            r_lo     <= HALF_NONE;
            r_hi     <= HALF_NONE;
            r_ready  <= 1'b1;
            r_up_ack <= '0;
            r_dn_req <= '0;
            r_to     <= 1'b0;
            r_sp     <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            if (r_state == IDLE && up_req.valid)
                r_req <= up_req;
            r_lo     <= w_lo;
            r_hi     <= w_hi;
            r_ready  <= w_nxt == IDLE;
            r_up_ack <= w_nxt == RESP ? w_up_ack : '0;
            r_dn_req <= (w_nxt == ISSUE_LO || w_nxt == ISSUE_HI) ? w_dn : '0;
            r_to     <= w_in_wait && w_tc && !w_ack;
            r_sp     <= w_ack && !w_in_wait;
        end
    end

    assign up_ready      = r_ready;
    assign up_ack        = r_up_ack;
    assign dn_req        = r_dn_req;
    assign timeout_pulse = r_to;
    assign spurious_ack  = r_sp;
endmodule
